instr_sequencer: RTL
====================

INSTR_SEQUENCER -- requirements
Module: instr_sequencer

Interface
REQ-001 The block SHALL have parameter DEPTH, default 16, meaning program-memory entries (power of two, 4..16).
REQ-002 The block SHALL have parameter AW, default 4, meaning program-counter width, with AW equal to log2(DEPTH).
REQ-003 The block SHALL have port clk, input, 1, the single clock; all logic is on its rising edge.
REQ-004 The block SHALL have port rst, input, 1, synchronous active-high reset.
REQ-005 The block SHALL have port load_en, input, 1, program-memory write strobe.
REQ-006 The block SHALL have port load_addr, input, AW, program-memory write address.
REQ-007 The block SHALL have port load_data, input, 11, instruction word: [10:8] opcode, [7:4] inp1, [3:0] inp2.
REQ-008 The block SHALL have port start, input, 1, single-cycle run request.
REQ-009 The block SHALL have port stall, input, 1, meaning hold the current issue and do not advance.
REQ-010 The block SHALL have port opcode, output, 3, registered opcode to the processor.
REQ-011 The block SHALL have ports inp1 and inp2, output, 4 each, registered operands to the processor.
REQ-012 The block SHALL have port reg_w_enable, output, 1, registered register-write enable to the processor.
REQ-013 The block SHALL have port issue_valid, output, 1, meaning opcode/inp1/inp2 hold a live instruction this cycle.
REQ-014 The block SHALL have port busy, output, 1, high in RUN.
REQ-015 The block SHALL have port done, output, 1, one-cycle pulse at program end.
REQ-016 The block SHALL have ports pc, output, AW, current fetch address; issue_cnt, output, 5, instructions issued; bad_cnt, output, 4, invalid opcodes issued.

Function
REQ-017 States SHALL be IDLE, RUN and DONE, encoded 2 bits.
REQ-018 In IDLE, load_en=1 SHALL write load_data to mem[load_addr] at the clock edge; in RUN and DONE, load_en SHALL be ignored.
REQ-019 IDLE with start=1 SHALL go to RUN, clear pc, issue_cnt and bad_cnt, and issue nothing that cycle.
REQ-020 In RUN with stall=0, each cycle SHALL register mem[pc] onto opcode/inp1/inp2, set issue_valid=1 and increment pc (one instruction per cycle, 1-cycle latency from pc to outputs).
REQ-021 In RUN with stall=1, outputs, pc and counters SHALL hold, and reg_w_enable SHALL be held at 0 during the stall cycle.
REQ-022 reg_w_enable SHALL be 1 exactly when issue_valid=1 and the issued opcode is 3'b100.
REQ-023 Opcode 3'b111 SHALL be HALT: on fetch, it SHALL not be issued (issue_valid=0, outputs zero), pc SHALL hold, and the state SHALL go to DONE.
REQ-024 The block SHALL go to DONE after the instruction at pc=DEPTH-1 issues; pc SHALL wrap to 0 and SHALL not re-fetch.
REQ-025 issue_cnt SHALL increment per issued instruction, with a maximum of DEPTH.
REQ-026 bad_cnt SHALL increment per issued opcode 3'b101 or 3'b110 and saturate at 15; invalid opcodes SHALL still be issued.
REQ-027 DONE SHALL assert done=1 and issue_valid=0 for exactly one cycle, then return to IDLE; counters SHALL hold until the next start.
REQ-028 start SHALL be ignored outside IDLE.
REQ-029 When stall=1 and HALT is fetched in the same cycle, stall SHALL take precedence; HALT SHALL be acted on in the first unstalled cycle.

Reset
REQ-030 rst=1 SHALL, at the clock edge and from any state, force IDLE and zero pc, opcode, inp1, inp2, reg_w_enable, issue_valid, busy, done, issue_cnt and bad_cnt.
REQ-031 Program memory contents SHALL be preserved across rst.
REQ-032 rst SHALL override start, load_en and stall in the same cycle.

Structure
REQ-033 A shared package SHALL hold the state enumeration, the opcode constants (ADD/SUB/AND/OR 000-011, WRITE 100, HALT 111) and the instruction field positions.
REQ-034 Program memory SHALL be a sub-module instr_mem (DEPTH x 11 bits, synchronous write, combinational read); the sequencer FSM and counters SHALL be in instr_sequencer.

Verification
REQ-035 Load mem[0]=100_0011_0101, mem[1]=000_0011_0001, mem[2]=111_xxxx_xxxx, then start -> cycle+1 opcode=100, inp1=3, inp2=5, reg_w_enable=1; cycle+2 opcode=000, reg_w_enable=0; then done pulse, issue_cnt=2.
REQ-036 Load all 16 entries with 001 and no HALT -> 16 consecutive issues, pc wraps to 0, done pulses once, issue_cnt=16.
REQ-037 Hold stall=1 for 3 cycles mid-run -> outputs unchanged, reg_w_enable=0, pc unchanged, and the program resumes without skipping.
REQ-038 Program containing 101, 110 and 110 before HALT -> bad_cnt=3, all three issued with reg_w_enable=0.
REQ-039 Assert rst in RUN at pc=5 -> next cycle IDLE with all outputs 0; a new start replays the program unchanged from pc=0.
REQ-040 Apply load_en during RUN targeting mem[3] -> memory unchanged; the originally loaded instruction 3 is issued.

Source files
------------

// File: rtl/instr_sequencer_pkg.sv
// Shared definitions for the instruction sequencer: FSM states, opcode
// encodings and the field layout of the 11-bit instruction word.
package instr_sequencer_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  localparam int IW = 11;

  localparam int OPC_MSB  = 10;
  localparam int OPC_LSB  = 8;
  localparam int INP1_MSB = 7;
  localparam int INP1_LSB = 4;
  localparam int INP2_MSB = 3;
  localparam int INP2_LSB = 0;

  localparam logic [2:0] OP_ADD   = 3'b000;
  localparam logic [2:0] OP_SUB   = 3'b001;
  localparam logic [2:0] OP_AND   = 3'b010;
  localparam logic [2:0] OP_OR    = 3'b011;
  localparam logic [2:0] OP_WRITE = 3'b100;
  localparam logic [2:0] OP_HALT  = 3'b111;

  // 101 and 110 have no defined meaning; they are issued but counted as bad
  function automatic logic is_bad_op(input logic [2:0] op);
    return (op == 3'b101) || (op == 3'b110);
  endfunction

endpackage

// File: rtl/instr_sequencer_mem.sv
// Program memory for the sequencer: synchronous write port, combinational
// read port. Contents are deliberately not reset.
module instr_mem
  import instr_sequencer_pkg::*;
#(
  parameter int DEPTH = 16,
  parameter int AW    = 4
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [IW-1:0] wdata,
  input  logic [AW-1:0] raddr,
  output logic [IW-1:0] rdata
);

  logic [IW-1:0] mem_r [DEPTH];

  // Write port
  always_ff @(posedge clk) begin
    if (we) begin
      mem_r[waddr] <= wdata;
    end
  end

  assign rdata = mem_r[raddr];

endmodule

// File: rtl/instr_sequencer.sv
// Instruction sequencer: loads a program while idle, then issues one
// instruction per cycle to the processor until HALT or the end of memory.
module instr_sequencer
  import instr_sequencer_pkg::*;
#(
  parameter int DEPTH = 16,
  parameter int AW    = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          load_en,
  input  logic [AW-1:0] load_addr,
  input  logic [10:0]   load_data,
  input  logic          start,
  input  logic          stall,
  output logic [2:0]    opcode,
  output logic [3:0]    inp1,
  output logic [3:0]    inp2,
  output logic          reg_w_enable,
  output logic          issue_valid,
  output logic          busy,
  output logic          done,
  output logic [AW-1:0] pc,
  output logic [4:0]    issue_cnt,
  output logic [3:0]    bad_cnt
);

  localparam logic [AW-1:0] PC_LAST = AW'(DEPTH - 1);

  state_e        state_r;
  logic          last_r;
  logic          mem_we_s;
  logic [IW-1:0] fetch_s;
  logic [2:0]    fetch_op_s;
  logic [3:0]    fetch_inp1_s;
  logic [3:0]    fetch_inp2_s;

  assign mem_we_s     = load_en && (state_r == ST_IDLE) && !rst;
  assign fetch_op_s   = fetch_s[OPC_MSB:OPC_LSB];
  assign fetch_inp1_s = fetch_s[INP1_MSB:INP1_LSB];
  assign fetch_inp2_s = fetch_s[INP2_MSB:INP2_LSB];

  instr_mem #(
    .DEPTH(DEPTH),
    .AW   (AW)
  ) u_instr_mem (
    .clk  (clk),
    .we   (mem_we_s),
    .waddr(load_addr),
    .wdata(load_data),
    .raddr(pc),
    .rdata(fetch_s)
  );

  // Sequencer FSM, issue registers and counters
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r      <= ST_IDLE;
      last_r       <= 1'b0;
      pc           <= '0;
      opcode       <= 3'b000;
      inp1         <= 4'h0;
      inp2         <= 4'h0;
      reg_w_enable <= 1'b0;
      issue_valid  <= 1'b0;
      busy         <= 1'b0;
      done         <= 1'b0;
      issue_cnt    <= 5'd0;
      bad_cnt      <= 4'd0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          done         <= 1'b0;
          issue_valid  <= 1'b0;
          reg_w_enable <= 1'b0;
          if (start) begin
            state_r   <= ST_RUN;
            busy      <= 1'b1;
            last_r    <= 1'b0;
            pc        <= '0;
            issue_cnt <= 5'd0;
            bad_cnt   <= 4'd0;
          end
        end
        ST_RUN: begin
          if (stall) begin
            reg_w_enable <= 1'b0;
          end else if (last_r || (fetch_op_s == OP_HALT)) begin
            // last_r: the final entry issued last cycle and pc has wrapped
            state_r      <= ST_DONE;
            last_r       <= 1'b0;
            busy         <= 1'b0;
            done         <= 1'b1;
            issue_valid  <= 1'b0;
            reg_w_enable <= 1'b0;
            opcode       <= 3'b000;
            inp1         <= 4'h0;
            inp2         <= 4'h0;
          end else begin
            opcode       <= fetch_op_s;
            inp1         <= fetch_inp1_s;
            inp2         <= fetch_inp2_s;
            issue_valid  <= 1'b1;
            reg_w_enable <= (fetch_op_s == OP_WRITE);
            pc           <= pc + AW'(1);
            last_r       <= (pc == PC_LAST);
            issue_cnt    <= issue_cnt + 5'd1;
            if (is_bad_op(fetch_op_s) && (bad_cnt != 4'hF)) begin
              bad_cnt <= bad_cnt + 4'd1;
            end
          end
        end
        ST_DONE: begin
          state_r <= ST_IDLE;
          done    <= 1'b0;
        end
        default: begin
          state_r      <= ST_IDLE;
          busy         <= 1'b0;
          done         <= 1'b0;
          issue_valid  <= 1'b0;
          reg_w_enable <= 1'b0;
        end
      endcase
    end
  end

endmodule
